// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: framed byte stream -> sequential 32-bit word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 payload checksum byte.
module imem_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CAP      = 32'(1) << ADDR_W;
   localparam logic [7:0]  SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM,
`else
      S_FLUSH,
`endif
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] len_q;
   logic [1:0]  byte_cnt_q;
   logic [23:0] shift_q;
   logic        accept_c;
   logic [15:0] n_c;
   logic        last_word_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q;
`endif

   assign accept_c    = in_valid && in_ready;
   assign n_c         = {in_data, len_q[7:0]};
   assign last_word_c = (32'(words_loaded) + 32'd1) == 32'(len_q);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_SYNC;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC:   if (accept_c && in_data == SYNC_BYTE) state_d = S_LEN_LO;
         S_LEN_LO: if (accept_c) state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (accept_c) begin
               if (n_c == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else if (32'(n_c) > CAP) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept_c && byte_cnt_q == 2'd3 && last_word_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_FLUSH;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:   if (accept_c) state_d = (in_data == sum_q) ? S_DONE : S_ERR;
`else
         // Lets the final write pulse complete before the core is released
         S_FLUSH:  state_d = S_DONE;
`endif
         default:  state_d = state_q;
      endcase
   end

   // Status outputs registered from the next state so they track state_q exactly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready  <= 1'b1;
         core_hold <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         in_ready  <= (state_d != S_DONE) && (state_d != S_ERR);
`else
         in_ready  <= (state_d != S_DONE) && (state_d != S_ERR) && (state_d != S_FLUSH);
`endif
         core_hold <= (state_d != S_DONE);
         done      <= (state_d == S_DONE);
         err       <= (state_d == S_ERR);
      end
   end

   // Length capture, word assembly and memory write strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q        <= '0;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (accept_c) begin
            case (state_q)
               S_LEN_LO: len_q[7:0]  <= in_data;
               S_LEN_HI: len_q[15:8] <= in_data;
               S_DATA: begin
                  shift_q    <= {in_data, shift_q[23:8]};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_q      <= sum_q + in_data;
`endif
                  if (byte_cnt_q == 2'd3) begin
                     mem_we       <= 1'b1;
                     mem_wdata    <= {in_data, shift_q};
                     mem_addr     <= words_loaded[ADDR_W-1:0];
                     words_loaded <= words_loaded + (ADDR_W+1)'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
